// File: rtl/wash_sequencer.sv
// wash_sequencer: steps a latched eight-phase wash program on the unit tick and drives the actuators.
// Optional door interlock: define WASH_SEQ_DOOR_LOCK_EN to add doorClosed/doorLock.
module wash_sequencer #(
  parameter int PHASE_UNIT = 1
) (
  input  logic        cp,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        pauseBtn,
  input  logic        abort,
  input  logic [25:0] program_word,
`ifdef WASH_SEQ_DOOR_LOCK_EN
  input  logic        doorClosed,
  output logic        doorLock,
`endif
  output logic        busy,
  output logic        paused,
  output logic [2:0]  phase,
  output logic [3:0]  phaseLeft,
  output logic [6:0]  totalLeft,
  output logic        inletValve,
  output logic        drainValve,
  output logic        motor,
  output logic        motorFast,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FINISH} state_t;
  state_t state;
  logic [25:0] prog;
  logic [7:0] sub;
  logic [3:0] nxt_start, nxt_run;
  logic door_ok, unit_done, run;
  function automatic logic [3:0] flen(input logic [25:0] p, input logic [2:0] i);
    case (i)
      3'd0: return {1'b0, p[25:23]};
      3'd1: return p[22:19];
      3'd2: return {1'b0, p[18:16]};
      3'd3: return {1'b0, p[15:13]};
      3'd4: return {1'b0, p[12:10]};
      3'd5: return p[9:6];
      3'd6: return {1'b0, p[5:3]};
      default: return {1'b0, p[2:0]};
    endcase
  endfunction
  // lowest nonzero phase at or above 'from'; 8 means none left
  function automatic logic [3:0] next_nz(input logic [25:0] p, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd8;
    for (int k = 7; k >= 0; k--)
      if (4'(k) >= from && flen(p, 3'(k)) != 4'd0) r = 4'(k);
    return r;
  endfunction
  function automatic logic [6:0] total(input logic [25:0] p);
    logic [6:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + {3'd0, flen(p, 3'(k))};
    return s;
  endfunction
`ifdef WASH_SEQ_DOOR_LOCK_EN
  assign door_ok = doorClosed;
  assign doorLock = busy;
`else
  assign door_ok = 1'b1;
`endif
  assign nxt_start = next_nz(program_word, 4'd0);
  assign nxt_run = next_nz(prog, {1'b0, phase} + 4'd1);
  assign unit_done = tick && sub == 8'(PHASE_UNIT - 1);
  always_ff @(posedge cp) begin
    if (reset) begin
      state <= IDLE;
      prog <= '0;
      sub <= '0;
      phase <= '0;
      phaseLeft <= '0;
      totalLeft <= '0;
    end else if (abort) begin
      state <= IDLE;
      sub <= '0;
      phase <= '0;
      phaseLeft <= '0;
      totalLeft <= '0;
    end else begin
      case (state)
        IDLE: if (start && door_ok) begin
          prog <= program_word;
          sub <= '0;
          phase <= nxt_start[3] ? 3'd0 : nxt_start[2:0];
          phaseLeft <= nxt_start[3] ? 4'd0 : flen(program_word, nxt_start[2:0]);
          totalLeft <= total(program_word);
          state <= nxt_start[3] ? FINISH : RUN;
        end
        RUN: if (pauseBtn || !door_ok) state <= PAUSE;
        else if (tick) begin
          sub <= unit_done ? 8'd0 : sub + 8'd1;
          if (unit_done) begin
            totalLeft <= (totalLeft == 7'd0) ? 7'd0 : totalLeft - 7'd1;
            if (phaseLeft == 4'd1) begin
              phase <= nxt_run[3] ? 3'd0 : nxt_run[2:0];
              phaseLeft <= nxt_run[3] ? 4'd0 : flen(prog, nxt_run[2:0]);
              state <= nxt_run[3] ? FINISH : RUN;
            end else phaseLeft <= phaseLeft - 4'd1;
          end
        end
        PAUSE: if (pauseBtn && door_ok) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end
  assign run = state == RUN;
  assign busy = run || state == PAUSE;
  assign paused = state == PAUSE;
  assign done = state == FINISH;
  assign inletValve = run && phase[1:0] == 2'b00;
  assign drainValve = run && phase[1];
  assign motor = run && phase[0];
  assign motorFast = run && &phase[1:0];
endmodule
